// File: rtl/scoreboard_ctrl.sv
// -----------------------------------------------------------------------------
// scoreboard_ctrl
//   Register-hazard scheduler at the ID/EX boundary. Tracks destination
//   registers that have writes outstanding from the long-latency units (MUL,
//   DIV, FPU). It raises a combinational hazard that holds the instruction in
//   ID/EX until the instruction's sources and destination are no longer
//   pending. ALU/MEM results are covered by forwarding and are never tracked.
//
//   Compile-time option:
//     SCOREBOARD_WB_BYPASS_EN - when defined, an entry that is being retired
//       by the writeback port this cycle already counts as free for the hazard
//       computation. MEM-to-ID forwarding in the register file supplies the
//       value. When undefined, the stall releases one cycle after writeback.
//
//   Ports:
//     clk, reset          clock, asynchronous active-high reset
//     id_valid            ID/EX holds a live instruction
//     id_rsN_addr/access  source N address / source N is read (N = 1..3)
//     id_rd_addr/access   destination address / destination is written
//     id_unit             producer: 0 ALU/MEM, 1 MUL, 2 DIV, 3 FPU
//     issue_fire          ID to EX transfer this cycle
//     wb_valid/addr/unit  register-file write port (MEM-stage writeback)
//     hazard              combinational stall request to ID
//     busy_mul/div/fpu    at least one write outstanding from that unit
//     pending_cnt         number of pending registers
//     err_orphan          sticky: writeback from a tracked unit with no match
// -----------------------------------------------------------------------------
module scoreboard_ctrl #(
   parameter int NUM_REGS = 64,
   parameter int ADDR_W   = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [ADDR_W-1:0] id_rs1_addr,
   input  logic              id_rs1_access,
   input  logic [ADDR_W-1:0] id_rs2_addr,
   input  logic              id_rs2_access,
   input  logic [ADDR_W-1:0] id_rs3_addr,
   input  logic              id_rs3_access,
   input  logic [ADDR_W-1:0] id_rd_addr,
   input  logic              id_rd_access,
   input  logic [1:0]        id_unit,
   input  logic              issue_fire,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [1:0]        wb_unit,
   output logic              hazard,
   output logic              busy_mul,
   output logic              busy_div,
   output logic              busy_fpu,
   output logic [ADDR_W:0]   pending_cnt,
   output logic              err_orphan
);

   localparam int CNT_W = ADDR_W + 1;
   localparam logic [1:0] UNIT_ALU = 2'd0;
   localparam logic [1:0] UNIT_MUL = 2'd1;
   localparam logic [1:0] UNIT_DIV = 2'd2;
   localparam logic [1:0] UNIT_FPU = 2'd3;

   logic [NUM_REGS-1:0]      pend_q, pend_d;
   logic [NUM_REGS-1:0][1:0] tag_q, tag_d;
   logic [NUM_REGS-1:0]      clr_mask;
   logic [NUM_REGS-1:0]      pend_haz;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     busy_mul_q, busy_mul_d;
   logic                     busy_div_q, busy_div_d;
   logic                     busy_fpu_q, busy_fpu_d;
   logic                     err_q, err_d;
   logic                     set_en, clr_en, orphan;
   logic                     cnt_inc, cnt_dec;
   logic                     raw, waw;

   always_comb begin
      // Entry 0 is never set, so it can never match a clear either.
      set_en = issue_fire && id_rd_access && (id_unit != UNIT_ALU) &&
               (id_rd_addr != '0);
      clr_en = wb_valid && pend_q[wb_addr] && (tag_q[wb_addr] == wb_unit);
      orphan = wb_valid && (wb_unit != UNIT_ALU) && (wb_addr != '0) && !clr_en;

      clr_mask = '0;
      if (clr_en) clr_mask[wb_addr] = 1'b1;

      // Set is applied after clear so a same-address collision keeps the
      // entry pending under the new producer.
      pend_d = pend_q & ~clr_mask;
      tag_d  = tag_q;
      if (set_en) begin
         pend_d[id_rd_addr] = 1'b1;
         tag_d[id_rd_addr]  = id_unit;
      end

      // Only a newly pending entry counts up; a clear that is overridden by a
      // same-address set does not count down.
      cnt_inc = set_en && !pend_q[id_rd_addr];
      cnt_dec = clr_en && !(set_en && (id_rd_addr == wb_addr));
      cnt_d   = cnt_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);

      busy_mul_d = 1'b0;
      busy_div_d = 1'b0;
      busy_fpu_d = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         busy_mul_d = busy_mul_d | (pend_d[i] && (tag_d[i] == UNIT_MUL));
         busy_div_d = busy_div_d | (pend_d[i] && (tag_d[i] == UNIT_DIV));
         busy_fpu_d = busy_fpu_d | (pend_d[i] && (tag_d[i] == UNIT_FPU));
      end

      err_d = err_q | orphan;
   end

   // Pending view used for stalling; with the bypass an entry retiring this
   // cycle is already treated as free.
   always_comb begin
`ifdef SCOREBOARD_WB_BYPASS_EN
      pend_haz = pend_q & ~clr_mask;
`else
      pend_haz = pend_q;
`endif
      raw = (id_rs1_access && pend_haz[id_rs1_addr]) ||
            (id_rs2_access && pend_haz[id_rs2_addr]) ||
            (id_rs3_access && pend_haz[id_rs3_addr]);
      waw = id_rd_access && pend_haz[id_rd_addr];
      hazard = id_valid && (raw || waw);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_q     <= '0;
         tag_q      <= '0;
         cnt_q      <= '0;
         busy_mul_q <= 1'b0;
         busy_div_q <= 1'b0;
         busy_fpu_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         pend_q     <= pend_d;
         tag_q      <= tag_d;
         cnt_q      <= cnt_d;
         busy_mul_q <= busy_mul_d;
         busy_div_q <= busy_div_d;
         busy_fpu_q <= busy_fpu_d;
         err_q      <= err_d;
      end
   end

   assign busy_mul    = busy_mul_q;
   assign busy_div    = busy_div_q;
   assign busy_fpu    = busy_fpu_q;
   assign pending_cnt = cnt_q;
   assign err_orphan  = err_q;

   a_cnt_popcount: assert property (@(posedge clk) disable iff (reset)
      cnt_q == CNT_W'($countones(pend_q)));

   a_no_issue_on_hazard: assert property (@(posedge clk) disable iff (reset)
      !(issue_fire && hazard));

endmodule

// File: tb/tb_scoreboard_ctrl.sv
module tb_scoreboard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_valid;
   logic [5:0] id_rs1_addr, id_rs2_addr, id_rs3_addr, id_rd_addr;
   logic       id_rs1_access, id_rs2_access, id_rs3_access, id_rd_access;
   logic [1:0] id_unit;
   logic       issue_fire;
   logic       wb_valid;
   logic [5:0] wb_addr;
   logic [1:0] wb_unit;
   logic       hazard, busy_mul, busy_div, busy_fpu, err_orphan;
   logic [6:0] pending_cnt;

   int checks = 0;
   int passed = 0;

   scoreboard_ctrl #(.NUM_REGS(64), .ADDR_W(6)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .id_rs1_addr(id_rs1_addr), .id_rs1_access(id_rs1_access),
      .id_rs2_addr(id_rs2_addr), .id_rs2_access(id_rs2_access),
      .id_rs3_addr(id_rs3_addr), .id_rs3_access(id_rs3_access),
      .id_rd_addr(id_rd_addr), .id_rd_access(id_rd_access),
      .id_unit(id_unit), .issue_fire(issue_fire),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_unit(wb_unit),
      .hazard(hazard), .busy_mul(busy_mul), .busy_div(busy_div),
      .busy_fpu(busy_fpu), .pending_cnt(pending_cnt), .err_orphan(err_orphan)
   );

   always #5 clk = ~clk;

   // Inputs change on the falling edge; registered outputs are read there too.
   task automatic idle_inputs();
      id_valid = 0; issue_fire = 0; wb_valid = 0;
      id_rs1_access = 0; id_rs2_access = 0; id_rs3_access = 0; id_rd_access = 0;
      id_rs1_addr = 0; id_rs2_addr = 0; id_rs3_addr = 0; id_rd_addr = 0;
      id_unit = 0; wb_addr = 0; wb_unit = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic issue(input logic [5:0] rd, input logic [1:0] unit);
      id_valid = 1; id_rd_access = 1; id_rd_addr = rd; id_unit = unit;
      issue_fire = 1;
      tick();
      id_valid = 0; id_rd_access = 0; issue_fire = 0;
   endtask

   task automatic test_reset();
      #1;
      checks++; if (hazard !== 1'b0) $display("FAIL reset_hazard got %b want 0", hazard); else passed++;
      checks++; if (pending_cnt !== 7'd0) $display("FAIL reset_cnt got %0d want 0", pending_cnt); else passed++;
      checks++; if ({busy_mul, busy_div, busy_fpu} !== 3'b000)
         $display("FAIL reset_busy got %b want 000", {busy_mul, busy_div, busy_fpu}); else passed++;
      checks++; if (err_orphan !== 1'b0) $display("FAIL reset_err got %b want 0", err_orphan); else passed++;
      @(negedge clk);
      reset = 0;
      tick();
   endtask

   task automatic test_issue_mul();
      id_valid = 1; id_rs1_access = 1; id_rs1_addr = 5; #1;
      checks++; if (hazard !== 1'b0) $display("FAIL idle_no_hazard got %b want 0", hazard); else passed++;
      idle_inputs();
      issue(6'd5, 2'd1);
      checks++; if (pending_cnt !== 7'd1) $display("FAIL mul_cnt got %0d want 1", pending_cnt); else passed++;
      checks++; if (busy_mul !== 1'b1) $display("FAIL mul_busy got %b want 1", busy_mul); else passed++;
      checks++; if ({busy_div, busy_fpu} !== 2'b00)
         $display("FAIL mul_other_busy got %b want 00", {busy_div, busy_fpu}); else passed++;
   endtask

   task automatic test_raw_release();
      id_valid = 1; id_rs2_access = 1; id_rs2_addr = 5; #1;
      checks++; if (hazard !== 1'b1) $display("FAIL raw_hazard got %b want 1", hazard); else passed++;
      id_valid = 0; #1;
      checks++; if (hazard !== 1'b0) $display("FAIL raw_not_valid got %b want 0", hazard); else passed++;
      id_valid = 1; id_rs2_access = 0; id_rd_access = 1; id_rd_addr = 5; #1;
      checks++; if (hazard !== 1'b1) $display("FAIL waw_hazard got %b want 1", hazard); else passed++;
      id_rd_access = 0; id_rs2_access = 1;
      wb_valid = 1; wb_addr = 5; wb_unit = 1; #1;
`ifdef SCOREBOARD_WB_BYPASS_EN
      checks++; if (hazard !== 1'b0) $display("FAIL wb_same_cycle got %b want 0", hazard); else passed++;
`else
      checks++; if (hazard !== 1'b1) $display("FAIL wb_same_cycle got %b want 1", hazard); else passed++;
`endif
      tick();
      wb_valid = 0; #1;
      checks++; if (hazard !== 1'b0) $display("FAIL wb_next_cycle got %b want 0", hazard); else passed++;
      checks++; if (pending_cnt !== 7'd0) $display("FAIL wb_cnt got %0d want 0", pending_cnt); else passed++;
      checks++; if (busy_mul !== 1'b0) $display("FAIL wb_busy_mul got %b want 0", busy_mul); else passed++;
      checks++; if (err_orphan !== 1'b0) $display("FAIL wb_err got %b want 0", err_orphan); else passed++;
      idle_inputs();
   endtask

   task automatic test_rd_zero();
      issue(6'd0, 2'd2);
      checks++; if (pending_cnt !== 7'd0) $display("FAIL rd0_cnt got %0d want 0", pending_cnt); else passed++;
      checks++; if (busy_div !== 1'b0) $display("FAIL rd0_busy_div got %b want 0", busy_div); else passed++;
      id_valid = 1; id_rs1_access = 1; id_rs1_addr = 0; #1;
      checks++; if (hazard !== 1'b0) $display("FAIL rd0_hazard got %b want 0", hazard); else passed++;
      idle_inputs();
   endtask

   task automatic test_set_clear_diff();
      issue(6'd5, 2'd1);
      wb_valid = 1; wb_addr = 5; wb_unit = 1;
      issue(6'd40, 2'd3);
      wb_valid = 0;
      checks++; if (pending_cnt !== 7'd1) $display("FAIL sc_cnt got %0d want 1", pending_cnt); else passed++;
      checks++; if (busy_fpu !== 1'b1) $display("FAIL sc_busy_fpu got %b want 1", busy_fpu); else passed++;
      checks++; if (busy_mul !== 1'b0) $display("FAIL sc_busy_mul got %b want 0", busy_mul); else passed++;
      id_valid = 1; id_rs3_access = 1; id_rs3_addr = 40; #1;
      checks++; if (hazard !== 1'b1) $display("FAIL sc_hazard40 got %b want 1", hazard); else passed++;
      id_rs3_addr = 5; #1;
      checks++; if (hazard !== 1'b0) $display("FAIL sc_hazard5 got %b want 0", hazard); else passed++;
      idle_inputs();
      wb_valid = 1; wb_addr = 40; wb_unit = 3;
      tick();
      wb_valid = 0;
      checks++; if (pending_cnt !== 7'd0) $display("FAIL sc_drain got %0d want 0", pending_cnt); else passed++;
      checks++; if (err_orphan !== 1'b0) $display("FAIL sc_err got %b want 0", err_orphan); else passed++;
   endtask

   task automatic test_orphan();
      wb_valid = 1; wb_addr = 7; wb_unit = 0;
      tick();
      checks++; if (err_orphan !== 1'b0) $display("FAIL alu_wb_err got %b want 0", err_orphan); else passed++;
      wb_unit = 3;
      tick();
      wb_valid = 0;
      checks++; if (err_orphan !== 1'b1) $display("FAIL orphan_err got %b want 1", err_orphan); else passed++;
      checks++; if (pending_cnt !== 7'd0) $display("FAIL orphan_cnt got %0d want 0", pending_cnt); else passed++;
      tick(); tick();
      checks++; if (err_orphan !== 1'b1) $display("FAIL orphan_sticky got %b want 1", err_orphan); else passed++;
      // Tag mismatch: MUL-owned reg 9 written back by DIV stays pending.
      issue(6'd9, 2'd1);
      wb_valid = 1; wb_addr = 9; wb_unit = 2;
      tick();
      wb_valid = 0;
      checks++; if (pending_cnt !== 7'd1) $display("FAIL mismatch_cnt got %0d want 1", pending_cnt); else passed++;
      checks++; if ({busy_mul, busy_div} !== 2'b10)
         $display("FAIL mismatch_busy got %b want 10", {busy_mul, busy_div}); else passed++;
   endtask

   task automatic test_mid_reset();
      logic [1:0] u;
      for (int i = 0; i < 10; i++) begin
         u = 2'(i % 3 + 1);
         issue(6'(10 + i), u);
      end
      checks++; if (pending_cnt !== 7'd11) $display("FAIL fill_cnt got %0d want 11", pending_cnt); else passed++;
      checks++; if ({busy_mul, busy_div, busy_fpu} !== 3'b111)
         $display("FAIL fill_busy got %b want 111", {busy_mul, busy_div, busy_fpu}); else passed++;
      id_valid = 1; id_rs1_access = 1; id_rs1_addr = 19; #1;
      checks++; if (hazard !== 1'b1) $display("FAIL fill_hazard got %b want 1", hazard); else passed++;
      #1 reset = 1; #1;
      checks++; if (pending_cnt !== 7'd0) $display("FAIL async_cnt got %0d want 0", pending_cnt); else passed++;
      checks++; if ({busy_mul, busy_div, busy_fpu} !== 3'b000)
         $display("FAIL async_busy got %b want 000", {busy_mul, busy_div, busy_fpu}); else passed++;
      checks++; if (err_orphan !== 1'b0) $display("FAIL async_err got %b want 0", err_orphan); else passed++;
      checks++; if (hazard !== 1'b0) $display("FAIL async_hazard got %b want 0", hazard); else passed++;
      @(negedge clk);
      reset = 0;
      tick();
      #1;
      checks++; if (hazard !== 1'b0) $display("FAIL post_reset_hazard got %b want 0", hazard); else passed++;
      idle_inputs();
   endtask

   initial begin
      reset = 1;
      idle_inputs();
      @(negedge clk);
      test_reset();
      test_issue_mul();
      test_raw_release();
      test_rd_zero();
      test_set_clear_diff();
      test_orphan();
      test_mid_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/scoreboard_ctrl.md
Name: scoreboard_ctrl

Overview:
- Register-hazard scheduler for the ID/EX boundary.
- Tracks destination registers with writes outstanding from the long-latency units (MUL, DIV, FPU) and raises a hazard that holds the instruction in the ID/EX registers until its sources and destination are free.
- Pending state is set when an instruction leaves ID into EX and cleared when the shared register-file write port (MEM-stage writeback) retires it.
- ALU/MEM results are covered by forwarding and are never tracked.

Parameters:
- NUM_REGS, 64, register-file entries (0-31 integer, 32-63 FP); must be a power of two.
- ADDR_W, 6, register address width, equal to log2(NUM_REGS).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  ID/EX register holds a live instruction (already killed on mispredict)
- id_rs1_addr  in  ADDR_W  source 1 address
- id_rs1_access  in  1  source 1 is read
- id_rs2_addr  in  ADDR_W  source 2 address
- id_rs2_access  in  1  source 2 is read
- id_rs3_addr  in  ADDR_W  source 3 address
- id_rs3_access  in  1  source 3 is read
- id_rd_addr  in  ADDR_W  destination address
- id_rd_access  in  1  destination is written
- id_unit  in  2  producer: 0 ALU/MEM, 1 MUL, 2 DIV, 3 FPU
- issue_fire  in  1  ID to EX transfer this cycle
- wb_valid  in  1  register-file write this cycle
- wb_addr  in  ADDR_W  written address
- wb_unit  in  2  producer of the written value (same encoding as id_unit)
- hazard  out  1  combinational stall request to ID
- busy_mul  out  1  at least one MUL write outstanding
- busy_div  out  1  at least one DIV write outstanding
- busy_fpu  out  1  at least one FPU write outstanding
- pending_cnt  out  ADDR_W+1  number of pending registers
- err_orphan  out  1  sticky error flag

Behaviour:
- State per register: pend[i] (1 bit) and tag[i] (2 bits). Entry 0 (x0) is hardwired not pending.
- Reset (asynchronous): all pend and tag bits = 0, pending_cnt = 0, busy_* = 0, err_orphan = 0, hazard = 0.
- Hazard is combinational: hazard = id_valid && (RAW || WAW).
  - RAW: any rsN_access with pend[rsN_addr] = 1.
  - WAW: id_rd_access with pend[id_rd_addr] = 1.
- The producer must not assert issue_fire while hazard = 1. If it does, the cycle is still processed as an issue; checking this is a verification assertion, not RTL behaviour.
- Set: when issue_fire && id_rd_access && id_unit != 0 && id_rd_addr != 0, then pend[rd] <= 1 and tag[rd] <= id_unit on the next edge.
- Clear: when wb_valid && pend[wb_addr] && tag[wb_addr] == wb_unit, then pend[wb_addr] <= 0 on the next edge.
- A writeback with wb_unit = 0, or a tag mismatch, leaves pend unchanged.
- Orphan error: wb_valid && wb_unit != 0 && wb_addr != 0 && !(pend[wb_addr] && tag matches) sets err_orphan, which holds until reset.
- Set and clear on the same address in the same cycle: set wins, pend stays 1 and the tag takes the new unit. WAW stalling makes this reachable only through the bypass path.
- Set and clear on different addresses in the same cycle: both take effect, and pending_cnt is unchanged.
- pending_cnt is a registered counter: +1 on set of a not-pending entry, -1 on clear, net 0 when both occur. It must never exceed NUM_REGS-1 and never underflow; an assertion checks it against the popcount of pend.
- busy_*: registered, equal to the OR over i of (pend[i] && tag[i] == unit), updated from the next-state vector.
- Latency: set is visible to hazard one cycle after issue_fire. Clear is visible one cycle after wb_valid, unless the optional bypass is compiled in.
- Reset mid-operation: all state is dropped. In-flight unit results arriving after reset raise err_orphan; by design the units are reset together with this block.

Optional Feature:
- Macro: SCOREBOARD_WB_BYPASS_EN.
- Defined: for the hazard computation only, an entry being cleared this cycle (same clear condition as above) counts as not pending. The RAW/WAW stall therefore releases in the same cycle as the writeback, relying on MEM-to-ID forwarding in the register file.
- Undefined: the stall releases one cycle after the writeback (one extra bubble).
- Registered state behaves identically in both builds.

Test Plan:
1. After reset: hazard = 0, pending_cnt = 0, busy_* = 0. Issue MUL rd = 5 -> next cycle pend[5] = 1, busy_mul = 1, pending_cnt = 1.
2. With pend[5] (MUL) set, an ID instruction reads rs2 = 5 -> hazard = 1. Then wb_valid, wb_addr = 5, wb_unit = 1 -> hazard drops the same cycle with bypass, the next cycle without; pending_cnt returns to 0.
3. Issue DIV to rd = 0 -> no state change, pending_cnt = 0, busy_div = 0.
4. Same cycle: issue FPU rd = 40 and writeback MUL rd = 5 (pending) -> pend[40] = 1, pend[5] = 0, pending_cnt unchanged, busy_fpu = 1, busy_mul = 0.
5. Writeback wb_unit = 3, wb_addr = 7 with reg 7 not pending -> err_orphan = 1 and stays 1; pend unchanged. An ALU writeback (wb_unit = 0) to reg 7 leaves err_orphan unaffected.
6. Fill 10 MUL/DIV/FPU registers, assert reset mid-stream -> all outputs 0 immediately (asynchronous), hazard = 0 on the next id_valid.
